// File: rtl/osw_multi_ctrl.sv
// N-channel latched optical-switch driver: edge-triggered ON/OFF commands become bounded drive
// pulses, with debounced status feedback, early feedback exit, sticky timeout errors and a cool-down.
module osw_multi_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 20,
  parameter int DEB_CYCLES  = 4096,
  parameter int COOL_CYCLES = 1024
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic [NUM_CH-1:0]     cmd_on,
  input  logic [NUM_CH-1:0]     cmd_off,
  input  logic [CNT_W-1:0]      drive_limit,
  input  logic                  fb_mode,
  input  logic                  err_clr,
  input  logic [NUM_CH-1:0]     osw_status0,
  input  logic [NUM_CH-1:0]     osw_status1,
  output logic [NUM_CH-1:0]     osw_drive0,
  output logic [NUM_CH-1:0]     osw_drive1,
  output logic [NUM_CH-1:0]     switch_on,
  output logic [NUM_CH-1:0]     switch_done,
  output logic [NUM_CH-1:0]     sw_error,
  output logic [NUM_CH-1:0]     busy,
  output logic [2*NUM_CH-1:0]   fsm_state
);

  localparam int DEB_W = $clog2(DEB_CYCLES) + 1;
  localparam int LINES = 2 * NUM_CH;
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRV_ON  = 2'd1,
    DRV_OFF = 2'd2,
    COOL    = 2'd3
  } state_e;

  // Lines [NUM_CH-1:0] carry status0 (ON settled), the upper half status1 (OFF settled).
  logic [LINES-1:0] pad, sync1_q, sync2_q, debRiseNow;
  logic [CNT_W-1:0] limitLast;

  assign pad       = {osw_status1, osw_status0};
  assign limitLast = (drive_limit == '0) ? '0 : drive_limit - CNT_W'(1);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pad;
      sync2_q <= sync1_q;
    end
  end

  for (genvar j = 0; j < LINES; j++) begin : g_deb
    logic             deb_q;
    logic [DEB_W-1:0] debCnt_q;
    logic             differ;

    assign differ        = sync2_q[j] ^ deb_q;
    // Rise is flagged in the same cycle the output is about to flip so feedback exit costs no extra cycle.
    assign debRiseNow[j] = differ & ~deb_q & (debCnt_q == DEB_LAST);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
        deb_q    <= 1'b0;
        debCnt_q <= '0;
      end else if (!differ) begin
        debCnt_q <= '0;
      end else if (debCnt_q == DEB_LAST) begin
        deb_q    <= sync2_q[j];
        debCnt_q <= '0;
      end else begin
        debCnt_q <= debCnt_q + DEB_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cmdOn_q, cmdOff_q;
    logic             drv0_q, drv1_q, err_q, done_q;
    logic             lastOn_q, lastOff_q;
    logic             reqOn, reqOff, accOn, accOff;
    logic             riseOn, riseOff, inDrive, targetRise, limitHit, driveExit, errSet;

    assign reqOn      = cmd_on[i] & ~cmdOn_q;
    assign reqOff     = cmd_off[i] & ~cmdOff_q;
    assign accOn      = (state_q == IDLE) & reqOn & ~reqOff;
    assign accOff     = (state_q == IDLE) & reqOff & ~reqOn;
    assign riseOn     = debRiseNow[i];
    assign riseOff    = debRiseNow[NUM_CH+i];
    assign inDrive    = (state_q == DRV_ON) | (state_q == DRV_OFF);
    assign targetRise = (state_q == DRV_ON) ? riseOn : riseOff;
    assign limitHit   = (cnt_q == limitLast);
    assign driveExit  = limitHit | (fb_mode & targetRise);
    // A timeout only counts as an error when feedback was expected and did not arrive in time.
    assign errSet     = inDrive & fb_mode & limitHit & ~targetRise;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        cmdOn_q   <= 1'b0;
        cmdOff_q  <= 1'b0;
        drv0_q    <= 1'b0;
        drv1_q    <= 1'b0;
        err_q     <= 1'b0;
        done_q    <= 1'b0;
        lastOn_q  <= 1'b0;
        lastOff_q <= 1'b0;
      end else begin
        cmdOn_q  <= cmd_on[i];
        cmdOff_q <= cmd_off[i];
        done_q   <= (riseOn & lastOn_q) | (riseOff & lastOff_q);
        err_q    <= err_clr ? 1'b0 : (err_q | errSet);
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (accOn) begin
              state_q   <= DRV_ON;
              drv0_q    <= 1'b1;
              lastOn_q  <= 1'b1;
              lastOff_q <= 1'b0;
            end else if (accOff) begin
              state_q   <= DRV_OFF;
              drv1_q    <= 1'b1;
              lastOn_q  <= 1'b0;
              lastOff_q <= 1'b1;
            end
          end
          DRV_ON, DRV_OFF: begin
            if (driveExit) begin
              state_q <= COOL;
              cnt_q   <= '0;
              drv0_q  <= 1'b0;
              drv1_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          COOL: begin
            if (cnt_q == COOL_LAST) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drv0_q  <= 1'b0;
            drv1_q  <= 1'b0;
          end
        endcase
      end
    end

    // switch_on is gated by reset so a command level held during reset stays silent until release.
    assign switch_on[i]        = accOn & S_AXI_ARESETN;
    assign osw_drive0[i]       = drv0_q;
    assign osw_drive1[i]       = drv1_q;
    assign switch_done[i]      = done_q;
    assign sw_error[i]         = err_q;
    assign busy[i]             = (state_q != IDLE);
    assign fsm_state[2*i +: 2] = state_q;
  end

endmodule
